// File: rtl/arb_pkg.sv
// Shared types and constants for the data memory arbiter slice.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser; the pointer names the winner on a tie.
module rr_pick2
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = PORT_CPU;
    if (req0 && req1) begin
      grant_id = pointer;
    end else if (req1) begin
      grant_id = PORT_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and debug (port 1) paths.
// Each access is IDLE -> ACCESS -> DONE; memory-side outputs are registered.
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData
);

  arb_state_e state_q, state_d;
  logic ptr_q, ptr_d;
  logic id_q, id_d;
  logic we_q, we_d;
  logic oor_q, oor_d;

  logic grant_valid, grant_id;
  logic              sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              ack0_d, ack1_d, err_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mem_writeData_d;
  logic              mem_memWrite_d, mem_memRead_d;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .pointer     (ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = (grant_id == PORT_DBG) ? we1    : we0;
  assign sel_addr  = (grant_id == PORT_DBG) ? addr1  : addr0;
  assign sel_wdata = (grant_id == PORT_DBG) ? wdata1 : wdata0;
  assign sel_oor   = (sel_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PORT_CPU;
      id_q          <= PORT_CPU;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      err           <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_memWrite  <= 1'b0;
      mem_memRead   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      we_q          <= we_d;
      oor_q         <= oor_d;
      ack0          <= ack0_d;
      ack1          <= ack1_d;
      err           <= err_d;
      rdata0        <= rdata0_d;
      rdata1        <= rdata1_d;
      mem_address   <= mem_address_d;
      mem_writeData <= mem_writeData_d;
      mem_memWrite  <= mem_memWrite_d;
      mem_memRead   <= mem_memRead_d;
    end
  end

  // The pointer only moves when both ports were asking.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    we_d    = we_q;
    oor_d   = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_ACCESS;
          id_d    = grant_id;
          we_d    = sel_we;
          oor_d   = sel_oor;
          if (req0 && req1) ptr_d = ~ptr_q;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Memory outputs are loaded at the grant edge so they are stable for the whole ACCESS cycle.
  always_comb begin
    mem_address_d   = mem_address;
    mem_writeData_d = mem_writeData;
    mem_memWrite_d  = 1'b0;
    mem_memRead_d   = 1'b0;
    ack0_d          = 1'b0;
    ack1_d          = 1'b0;
    err_d           = 1'b0;
    rdata0_d        = rdata0;
    rdata1_d        = rdata1;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          mem_address_d   = sel_addr;
          mem_writeData_d = sel_wdata;
          mem_memWrite_d  = sel_we & ~sel_oor;
          mem_memRead_d   = ~sel_we & ~sel_oor;
        end
      end
      ST_ACCESS: begin
        ack0_d = (id_q == PORT_CPU);
        ack1_d = (id_q == PORT_DBG);
        err_d  = oor_q;
        if (!we_q) begin
          if (id_q == PORT_DBG) rdata1_d = oor_q ? '0 : mem_readData;
          else                  rdata0_d = oor_q ? '0 : mem_readData;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_data_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk, reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData, mem_readData;
  logic          mem_memWrite, mem_memRead;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .we0           (we0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .ack0          (ack0),
    .rdata0        (rdata0),
    .req1          (req1),
    .we1           (we1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .ack1          (ack1),
    .rdata1        (rdata1),
    .err           (err),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_readData  (mem_readData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n++;

  // Environment memory: asynchronous read, write on negedge.
  logic [DW-1:0] mem [DEPTH];
  assign mem_readData = (mem_address < AW'(DEPTH)) ? mem[mem_address[2:0]] : '0;
  always @(negedge clk) begin
    if (mem_memWrite && mem_address < AW'(DEPTH)) mem[mem_address[2:0]] = mem_writeData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Transaction-level model: a grant occupies the two edges that follow it.
  logic [DW-1:0] shadow [DEPTH];
  bit            model_valid = 0;
  int            since_grant = 0;
  bit            m_ptr, t_id, t_we, t_oor;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, val;
  logic          e_ack0, e_ack1, e_err, e_rd, e_wr;
  logic [DW-1:0] e_rdata0, e_rdata1, e_wdata;
  logic [AW-1:0] e_addr;

  always @(posedge clk) begin
    if (!reset) begin
      model_valid = 1;
      since_grant = 0;
      m_ptr = 0;
      {e_ack0, e_ack1, e_err, e_rd, e_wr} = '0;
      e_rdata0 = '0;
      e_rdata1 = '0;
    end else if (model_valid) begin
      {e_ack0, e_ack1, e_err, e_rd, e_wr} = '0;
      if (since_grant == 0) begin
        if (req0 || req1) begin
          if (req0 && req1) begin
            t_id = m_ptr;
            m_ptr = !m_ptr;
          end else begin
            t_id = req1;
          end
          t_we    = t_id ? we1 : we0;
          t_addr  = t_id ? addr1 : addr0;
          t_wdata = t_id ? wdata1 : wdata0;
          t_oor   = (t_addr >= AW'(DEPTH));
          e_rd    = !t_we && !t_oor;
          e_wr    = t_we && !t_oor;
          e_addr  = t_addr;
          e_wdata = t_wdata;
          since_grant = 1;
        end
      end else if (since_grant == 1) begin
        if (t_id) e_ack1 = 1'b1;
        else      e_ack0 = 1'b1;
        e_err = t_oor;
        if (!t_we) begin
          val = t_oor ? '0 : shadow[t_addr[2:0]];
          if (t_id) e_rdata1 = val;
          else      e_rdata0 = val;
        end else if (!t_oor) begin
          shadow[t_addr[2:0]] = t_wdata;
        end
        since_grant = 2;
      end else begin
        since_grant = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("err", err, e_err);
      chk("rdata0", rdata0, e_rdata0);
      chk("rdata1", rdata1, e_rdata1);
      chk("mem_memRead", mem_memRead, e_rd);
      chk("mem_memWrite", mem_memWrite, e_wr);
      if (e_rd || e_wr) chk("mem_address", mem_address, e_addr);
      if (e_wr) chk("mem_writeData", mem_writeData, e_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic contest(input bit first);
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    cyc(); cyc();
    if (first == 0) begin
      chk("contest_first_ack0", ack0, 1);
      chk("contest_first_rdata0", rdata0, 32'd1);
      chk("contest_first_ack1_low", ack1, 0);
      req0 = 0;
    end else begin
      chk("contest_first_ack1", ack1, 1);
      chk("contest_first_rdata1", rdata1, 32'd2);
      chk("contest_first_ack0_low", ack0, 0);
      req1 = 0;
    end
    cyc(); cyc(); cyc();
    if (first == 0) begin
      chk("contest_second_ack1", ack1, 1);
      chk("contest_second_rdata1", rdata1, 32'd2);
      req1 = 0;
    end else begin
      chk("contest_second_ack0", ack0, 1);
      chk("contest_second_rdata0", rdata0, 32'd1);
      req0 = 0;
    end
    cyc();
  endtask

  task automatic new_req(input bit port);
    logic [AW-1:0] a;
    case ($urandom_range(7, 0))
      0:       a = 32'h0000_0103;
      1:       a = 32'h8000_0000 | AW'($urandom_range(7, 0));
      default: a = AW'($urandom_range(9, 0));
    endcase
    if (port) begin
      req1 = 1; we1 = 1'($urandom_range(1, 0)); addr1 = a; wdata1 = $urandom;
    end else begin
      req0 = 1; we0 = 1'($urandom_range(1, 0)); addr0 = a; wdata0 = $urandom;
    end
  endtask

  int t1, t2;
  logic a0, a1;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = DW'(i);
      shadow[i] = DW'(i);
    end
    reset = 0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) cyc();
    chk("reset_ack0", ack0, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_memRead", mem_memRead, 0);
    reset = 1;
    cyc();

    // Port 0 read of address 3.
    req0 = 1; we0 = 0; addr0 = 3;
    cyc();
    chk("rd3_mem_memRead", mem_memRead, 1);
    chk("rd3_mem_address", mem_address, 32'd3);
    req0 = 0;
    cyc();
    chk("rd3_ack0", ack0, 1);
    chk("rd3_rdata0", rdata0, 32'd3);
    chk("rd3_err", err, 0);
    cyc();

    // Port 1 write then read back address 5.
    req1 = 1; we1 = 1; addr1 = 5; wdata1 = 32'hDEAD_BEEF;
    cyc();
    chk("wr5_mem_memWrite", mem_memWrite, 1);
    req1 = 0;
    cyc();
    chk("wr5_ack1", ack1, 1);
    cyc();
    req1 = 1; we1 = 0;
    cyc();
    req1 = 0;
    cyc();
    chk("rd5_ack1", ack1, 1);
    chk("rd5_rdata1", rdata1, 32'hDEAD_BEEF);
    cyc();

    contest(0);
    contest(1);

    // Out-of-range write from port 0.
    req0 = 1; we0 = 1; addr0 = 8; wdata0 = 32'h1234_5678;
    cyc();
    chk("oor_no_memWrite", mem_memWrite, 0);
    req0 = 0;
    cyc();
    chk("oor_ack0", ack0, 1);
    chk("oor_err", err, 1);
    cyc();
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("oor_mem_intact", mem[i], (i == 5) ? 32'hDEAD_BEEF : 32'(i));
    end

    // Reset cut into a port 1 read; pointer must return to port 0.
    contest(0);
    req1 = 1; we1 = 0; addr1 = 4;
    cyc();
    chk("rst_mid_memRead", mem_memRead, 1);
    reset = 0; req1 = 0;
    cyc();
    chk("rst_mid_ack1", ack1, 0);
    chk("rst_mid_memRead_low", mem_memRead, 0);
    chk("rst_mid_memWrite_low", mem_memWrite, 0);
    reset = 1;
    cyc();
    contest(0);

    // Port 0 holds req through ack: back-to-back accesses 3 cycles apart.
    req0 = 1; we0 = 0; addr0 = 3;
    cyc(); cyc();
    chk("hold_ack0_first", ack0, 1);
    t1 = cyc_n;
    cyc(); cyc(); cyc();
    chk("hold_ack0_second", ack0, 1);
    t2 = cyc_n;
    chk("hold_spacing", 32'(t2 - t1), 32'd3);
    req0 = 0;
    cyc();

    // Random traffic; a requester changes its request only in the cycle after its ack.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      @(posedge clk);
      #1;
      if (req0) begin
        if (a0) begin
          if ($urandom_range(1, 0) == 0) req0 = 0;
          else new_req(1'b0);
        end
      end else if ($urandom_range(2, 0) == 0) begin
        new_req(1'b0);
      end
      if (req1) begin
        if (a1) begin
          if ($urandom_range(1, 0) == 0) req1 = 0;
          else new_req(1'b1);
        end
      end else if ($urandom_range(2, 0) == 0) begin
        new_req(1'b1);
      end
    end
    req0 = 0;
    req1 = 0;
    repeat (8) cyc();
    for (int i = 0; i < int'(DEPTH); i++) chk("final_mem", mem[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
